// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the VDP pixel stage.
// master drives the timing; slave is the consumer side.
interface vga_timing_gen_if;
    logic       pix_en;
    logic       HSync;
    logic       VSync;
    logic       blank;
    logic [8:0] row;
    logic [9:0] col;
    logic       in_window;
    logic [7:0] win_col;
    logic [7:0] win_row;
    logic       line_start;
    logic       frame_start;
    logic       vblank_irq;

    modport master (
        output pix_en, HSync, VSync, blank, row, col, in_window,
               win_col, win_row, line_start, frame_start, vblank_irq
    );

    modport slave (
        input pix_en, HSync, VSync, blank, row, col, in_window,
              win_col, win_row, line_start, frame_start, vblank_irq
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing on a clock-enable, with a 2x-scaled 256x192 window.
// Define VGA_PIPE_ALIGN_EN to delay HSync/VSync/blank by one pixel tick.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_VIS   = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter int unsigned WIN_X0  = 64,
    parameter int unsigned WIN_Y0  = 48
) (
    input logic              clk,
    input logic              rst_L,
    vga_timing_gen_if.master vga
);
    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
    localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] WX_BEG   = 10'(WIN_X0);
    localparam logic [9:0] WX_END   = 10'(WIN_X0 + 512);
    localparam logic [9:0] WY_BEG   = 10'(WIN_Y0);
    localparam logic [9:0] WY_END   = 10'(WIN_Y0 + 384);

    logic [3:0] divcnt;
    logic       pix_en_q;
    logic       started_q;
    logic [9:0] hcnt_q, vcnt_q;
    logic [9:0] hcnt_d, vcnt_d;
    logic [9:0] win_x_off, win_y_off;

    logic       hsync_d, vsync_d, blank_d, in_window_d;
    logic       line_start_d, frame_start_d, vblank_irq_d;
    logic [8:0] row_d;
    logic [7:0] win_col_d, win_row_d;

    logic       hsync_q, vsync_q, blank_q, in_window_q;
    logic       line_start_q, frame_start_q, vblank_irq_q;
    logic [8:0] row_q;
    logic [7:0] win_col_q, win_row_q;

    // The first tick after reset only publishes position (0,0); later ticks advance.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_en_q && started_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = 10'd0;
                vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end
    end

    always_comb begin
        hsync_d   = !((hcnt_d >= HS_BEG) && (hcnt_d < HS_END));
        vsync_d   = !((vcnt_d >= VS_BEG) && (vcnt_d < VS_END));
        blank_d   = (hcnt_d >= H_VIS_W) || (vcnt_d >= V_VIS_W);
        row_d     = (vcnt_d < V_VIS_W) ? vcnt_d[8:0] : 9'd0;
        // Range check first so the offset below never wraps when used.
        in_window_d = !blank_d && (hcnt_d >= WX_BEG) && (hcnt_d < WX_END) &&
                      (vcnt_d >= WY_BEG) && (vcnt_d < WY_END);
        win_x_off = hcnt_d - WX_BEG;
        win_y_off = vcnt_d - WY_BEG;
        win_col_d = in_window_d ? 8'(win_x_off >> 1) : 8'd0;
        win_row_d = in_window_d ? 8'(win_y_off >> 1) : 8'd0;
        line_start_d  = (hcnt_d == 10'd0);
        frame_start_d = line_start_d && (vcnt_d == 10'd0);
        vblank_irq_d  = line_start_d && (vcnt_d == V_VIS_W);
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            divcnt        <= 4'd0;
            pix_en_q      <= 1'b0;
            started_q     <= 1'b0;
            hcnt_q        <= 10'd0;
            vcnt_q        <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_q       <= 1'b1;
            row_q         <= 9'd0;
            in_window_q   <= 1'b0;
            win_col_q     <= 8'd0;
            win_row_q     <= 8'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_irq_q  <= 1'b0;
        end else begin
            divcnt        <= (divcnt == DIV_LAST) ? 4'd0 : divcnt + 4'd1;
            pix_en_q      <= (divcnt == DIV_LAST);
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_irq_q  <= 1'b0;
            if (pix_en_q) begin
                started_q     <= 1'b1;
                hcnt_q        <= hcnt_d;
                vcnt_q        <= vcnt_d;
                hsync_q       <= hsync_d;
                vsync_q       <= vsync_d;
                blank_q       <= blank_d;
                row_q         <= row_d;
                in_window_q   <= in_window_d;
                win_col_q     <= win_col_d;
                win_row_q     <= win_row_d;
                line_start_q  <= line_start_d;
                frame_start_q <= frame_start_d;
                vblank_irq_q  <= vblank_irq_d;
            end
        end
    end

    assign vga.pix_en      = pix_en_q;
    assign vga.row         = row_q;
    assign vga.col         = hcnt_q;
    assign vga.in_window   = in_window_q;
    assign vga.win_col     = win_col_q;
    assign vga.win_row     = win_row_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.vblank_irq  = vblank_irq_q;

`ifdef VGA_PIPE_ALIGN_EN
    // Matches the VDP's one-tick VRAM/CRAM lookup latency.
    logic hsync_dly_q, vsync_dly_q, blank_dly_q;

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            hsync_dly_q <= 1'b1;
            vsync_dly_q <= 1'b1;
            blank_dly_q <= 1'b1;
        end else if (pix_en_q) begin
            hsync_dly_q <= hsync_q;
            vsync_dly_q <= vsync_q;
            blank_dly_q <= blank_q;
        end
    end

    assign vga.HSync = hsync_dly_q;
    assign vga.VSync = vsync_dly_q;
    assign vga.blank = blank_dly_q;
`else
    assign vga.HSync = hsync_q;
    assign vga.VSync = vsync_q;
    assign vga.blank = blank_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Checks vga_timing_gen against a raster model derived from elapsed clocks since reset.
// Instance A: full 800-wide lines; instance B: tiny geometry so whole frames fit the run.
module tb_vga_timing_gen;
    typedef struct packed {
        logic       pix_en;
        logic       hs;
        logic       vs;
        logic       blank;
        logic [8:0] row;
        logic [9:0] col;
        logic       inw;
        logic [7:0] wc;
        logic [7:0] wr;
        logic       ls;
        logic       fs;
        logic       vi;
    } vo_t;

    typedef struct {
        int cd; int hv; int hfp; int hsw; int hbp;
        int vv; int vfp; int vsw; int vbp; int wx; int wy;
    } geom_t;

    localparam vo_t RST_VO = {1'b0, 1'b1, 1'b1, 1'b1, 9'd0, 10'd0, 1'b0, 8'd0, 8'd0,
                              1'b0, 1'b0, 1'b0};

    geom_t ga, gb;
    int    vectors, miscompares;

    logic clk, rst_a_L, rst_b_L;
    vga_timing_gen_if vga_a ();
    vga_timing_gen_if vga_b ();

    vga_timing_gen #(.WIN_Y0(1)) dut_a (
        .clk   (clk),
        .rst_L (rst_a_L),
        .vga   (vga_a)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .WIN_X0(4), .WIN_Y0(2)
    ) dut_b (
        .clk   (clk),
        .rst_L (rst_b_L),
        .vga   (vga_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sync/blank for raster position p (ticks after the first one).
    function automatic void sync_of(input int p, input geom_t g,
                                    output logic hs, output logic vs, output logic bl);
        int ht, vt, h, v;
        ht = g.hv + g.hfp + g.hsw + g.hbp;
        vt = g.vv + g.vfp + g.vsw + g.vbp;
        h  = p % ht;
        v  = (p / ht) % vt;
        hs = !(h >= g.hv + g.hfp && h < g.hv + g.hfp + g.hsw);
        vs = !(v >= g.vv + g.vfp && v < g.vv + g.vfp + g.vsw);
        bl = (h >= g.hv) || (v >= g.vv);
    endfunction

    // k = number of clk edges seen with reset released since the last reset edge.
    function automatic vo_t model(input int k, input geom_t g);
        vo_t  o;
        int   n, p, h, v, ht, vt;
        logic hs, vs, bl;
        o = RST_VO;
        if (k <= 0) return o;
        o.pix_en = (k % g.cd == 0);
        n = (k - 1) / g.cd;
        if (n == 0) return o;
        ht = g.hv + g.hfp + g.hsw + g.hbp;
        vt = g.vv + g.vfp + g.vsw + g.vbp;
        p  = n - 1;
        h  = p % ht;
        v  = (p / ht) % vt;
        sync_of(p, g, hs, vs, bl);
`ifdef VGA_PIPE_ALIGN_EN
        if (p == 0) begin
            hs = 1'b1; vs = 1'b1; bl = 1'b1;
        end else begin
            sync_of(p - 1, g, hs, vs, bl);
        end
`endif
        o.hs    = hs;
        o.vs    = vs;
        o.blank = bl;
        o.col   = 10'(h);
        o.row   = (v < g.vv) ? 9'(v) : 9'd0;
        o.inw   = (h < g.hv) && (v < g.vv) && h >= g.wx && h < g.wx + 512 &&
                  v >= g.wy && v < g.wy + 384;
        o.wc    = o.inw ? 8'((h - g.wx) / 2) : 8'd0;
        o.wr    = o.inw ? 8'((v - g.wy) / 2) : 8'd0;
        if ((k - 1) % g.cd == 0) begin
            o.ls = (h == 0);
            o.fs = (h == 0) && (v == 0);
            o.vi = (h == 0) && (v == g.vv);
        end
        return o;
    endfunction

    int cyc;
    always @(posedge clk) cyc++;

    // Instance A compare process.
    int   ka, a_phase, hs_low_a, last_ls_a, t_col656, t_hs_fall, t_col640, t_bl_rise;
    int   hit63, hit64, hit575r2, hit575r3, hit576;
    logic ra_s, prev_hs_a, prev_bl_a, have_ls_a;
    logic [9:0] prev_col_a;
    vo_t  got_a;

    always @(posedge clk) begin
        ra_s = rst_a_L;
        #1;
        ka = ra_s ? ka + 1 : 0;
        got_a = {vga_a.pix_en, vga_a.HSync, vga_a.VSync, vga_a.blank, vga_a.row, vga_a.col,
                 vga_a.in_window, vga_a.win_col, vga_a.win_row, vga_a.line_start,
                 vga_a.frame_start, vga_a.vblank_irq};
        chk("model_a", 64'(got_a), 64'(model(ka, ga)));
        if (ka == 0) begin
            chk("reset_vals_a", 64'(got_a), 64'(RST_VO));
            have_ls_a = 1'b0;
        end
        if (ka == 3) chk("pix_en_pre_a", 64'(vga_a.pix_en), 64'd0);
        if (ka == 4) chk("first_pix_en_a", 64'(vga_a.pix_en), 64'd1);
        if (ka == 5) begin
`ifndef VGA_PIPE_ALIGN_EN
            chk("first_blank_a", 64'(vga_a.blank), 64'd0);
`endif
            chk("first_pos_a", 64'({vga_a.col, 1'b0, vga_a.row}), 64'd0);
            chk("first_pulses_a", 64'({vga_a.frame_start, vga_a.line_start}), 64'd3);
        end
        if (ka == 6) chk("pulse_width_a", 64'({vga_a.frame_start, vga_a.line_start}), 64'd0);
        if (ka > 5) begin
            if (vga_a.col == 10'd63 && vga_a.row == 9'd1) begin
                hit63++;
                chk("win_c63", 64'(vga_a.in_window), 64'd0);
            end
            if (vga_a.col == 10'd64 && vga_a.row == 9'd1) begin
                hit64++;
                chk("win_c64", 64'({vga_a.in_window, vga_a.win_col, vga_a.win_row}),
                    64'h1_00_00);
            end
            if (vga_a.col == 10'd575 && vga_a.row == 9'd2) begin
                hit575r2++;
                chk("win_c575r2", 64'({vga_a.win_col, vga_a.win_row}), 64'hff_00);
            end
            if (vga_a.col == 10'd575 && vga_a.row == 9'd3) begin
                hit575r3++;
                chk("win_c575r3", 64'({vga_a.win_col, vga_a.win_row}), 64'hff_01);
            end
            if (vga_a.col == 10'd576 && vga_a.row == 9'd1) begin
                hit576++;
                chk("win_c576", 64'({vga_a.in_window, vga_a.win_col}), 64'd0);
            end
            if (vga_a.line_start) begin
                if (have_ls_a) chk("ls_period_a", 64'(cyc - last_ls_a), 64'd3200);
                have_ls_a = 1'b1;
                last_ls_a = cyc;
            end
            if (a_phase == 0 && (ka - 1) % 4 == 0 && vga_a.row == 9'd0 && !vga_a.HSync)
                hs_low_a++;
            if (t_col656 < 0 && vga_a.col == 10'd656 && prev_col_a != 10'd656) t_col656 = cyc;
            if (t_hs_fall < 0 && prev_hs_a && !vga_a.HSync) t_hs_fall = cyc;
            if (t_col640 < 0 && vga_a.col == 10'd640 && prev_col_a != 10'd640) t_col640 = cyc;
            if (t_bl_rise < 0 && !prev_bl_a && vga_a.blank) t_bl_rise = cyc;
        end
        prev_col_a = vga_a.col;
        prev_hs_a  = vga_a.HSync;
        prev_bl_a  = vga_a.blank;
    end

    // Instance B compare process: whole-frame properties.
    int   kb, frames_b, vs_low_b, vi_cnt_b, last_fs_b;
    logic rb_s;
    vo_t  got_b;

    always @(posedge clk) begin
        rb_s = rst_b_L;
        #1;
        kb = rb_s ? kb + 1 : 0;
        got_b = {vga_b.pix_en, vga_b.HSync, vga_b.VSync, vga_b.blank, vga_b.row, vga_b.col,
                 vga_b.in_window, vga_b.win_col, vga_b.win_row, vga_b.line_start,
                 vga_b.frame_start, vga_b.vblank_irq};
        chk("model_b", 64'(got_b), 64'(model(kb, gb)));
        if (kb > 0) begin
            if (vga_b.frame_start) begin
                if (frames_b > 0) begin
                    chk("fs_period_b", 64'(cyc - last_fs_b), 64'd1368);
                    chk("vs_ticks_b", 64'(vs_low_b), 64'd48);
                    chk("vi_count_b", 64'(vi_cnt_b), 64'd1);
                end
                frames_b++;
                last_fs_b = cyc;
                vs_low_b  = 0;
                vi_cnt_b  = 0;
            end
            if (vga_b.vblank_irq) begin
                vi_cnt_b++;
                chk("vi_pos_b", 64'({vga_b.col, 1'b0, vga_b.row}), 64'd0);
                chk("vi_delay_b", 64'(cyc - last_fs_b), 64'd864);
            end
            if (kb >= 4 && (kb - 1) % 3 == 0 && !vga_b.VSync) vs_low_b++;
        end
    end

    int to;

    initial begin
        ga = '{cd: 4, hv: 640, hfp: 16, hsw: 96, hbp: 48, vv: 480, vfp: 10, vsw: 2, vbp: 33,
               wx: 64, wy: 1};
        gb = '{cd: 3, hv: 16, hfp: 2, hsw: 4, hbp: 2, vv: 12, vfp: 2, vsw: 2, vbp: 3,
               wx: 4, wy: 2};
        vectors = 0; miscompares = 0; cyc = 0; ka = 0; kb = 0;
        a_phase = 0; hs_low_a = 0; last_ls_a = 0; have_ls_a = 1'b0;
        t_col656 = -1; t_hs_fall = -1; t_col640 = -1; t_bl_rise = -1;
        hit63 = 0; hit64 = 0; hit575r2 = 0; hit575r3 = 0; hit576 = 0;
        prev_col_a = 10'd0; prev_hs_a = 1'b1; prev_bl_a = 1'b1;
        frames_b = 0; vs_low_b = 0; vi_cnt_b = 0; last_fs_b = 0;
        rst_a_L = 1'b0;
        rst_b_L = 1'b0;
        repeat (3) @(negedge clk);
        rst_a_L = 1'b1;
        rst_b_L = 1'b1;

        to = 0;
        while (!(vga_a.col == 10'd700 && vga_a.row == 9'd3) && to < 20000) begin
            @(negedge clk);
            to++;
        end
        chk("reach_col700", 64'(to < 20000), 64'd1);

        // One-clk reset mid-line; restart is checked by the model and the ka==5 probes.
        rst_a_L = 1'b0;
        a_phase = 1;
        @(negedge clk);
        rst_a_L = 1'b1;
        repeat (4000) @(negedge clk);

        chk("hs_low_ticks_a", 64'(hs_low_a), 64'd96);
`ifdef VGA_PIPE_ALIGN_EN
        chk("hs_align_a", 64'(t_hs_fall - t_col656), 64'd4);
        chk("bl_align_a", 64'(t_bl_rise - t_col640), 64'd4);
`else
        chk("hs_align_a", 64'(t_hs_fall - t_col656), 64'd0);
        chk("bl_align_a", 64'(t_bl_rise - t_col640), 64'd0);
`endif
        chk("probe_hits", 64'({hit63 > 0, hit64 > 0, hit575r2 > 0, hit575r3 > 0, hit576 > 0}),
            64'h1f);
        chk("frames_b", 64'(frames_b >= 3), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA raster timing from the 100 MHz system clock, using a clock-enable rather than a derived 25 MHz clock.
- Produces HSync/VSync, blanking, raster row/col and a 2x-scaled 256x192 window coordinate for the VDP pixel stage.
- Sits directly upstream of the VDP pixel/colour lookup, which consumes row/col and win_row/win_col, and downstream of the board clock/reset.

Parameters:
- CLK_DIV, 4, system clocks per pixel tick (100 MHz / 4 = 25 MHz); legal values 2..15.
- H_VIS, 640, visible columns.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, HSync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, VSync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- WIN_X0, 64, first visible column of the 512-wide scaled window.
- WIN_Y0, 48, first visible row of the 384-high scaled window.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_L  in  1  reset, synchronous, active low.
- pix_en  out  1  one-clk pulse every CLK_DIV clocks; marks a pixel tick.
- HSync  out  1  horizontal sync, active low.
- VSync  out  1  vertical sync, active low.
- blank  out  1  high outside the 640x480 visible area.
- row  out  9  visible line 0..479; 0 when vertically blanked.
- col  out  10  horizontal count 0..799; raw count, including blanking.
- in_window  out  1  high when col is in WIN_X0..WIN_X0+511 and row is in WIN_Y0..WIN_Y0+383, and blank=0.
- win_col  out  8  (col-WIN_X0)>>1 when in_window; else 0.
- win_row  out  8  (row-WIN_Y0)>>1 when in_window; else 0.
- line_start  out  1  one-clk pulse when hcnt wraps to 0.
- frame_start  out  1  one-clk pulse when hcnt and vcnt both wrap to 0.
- vblank_irq  out  1  one-clk pulse on entry to line V_VIS (480), at col 0.

Behaviour:
- Reset: while rst_L=0 at a clk edge, divcnt=0, hcnt=0, vcnt=0, pix_en=0, HSync=1, VSync=1, blank=1, row=0, col=0, in_window=0, win_row=0, win_col=0, line_start=0, frame_start=0, vblank_irq=0. Reset mid-frame aborts the frame immediately; there is no partial-line completion.
- Divider: divcnt counts 0..CLK_DIV-1 and wraps to 0. pix_en is registered and high for the one clk after divcnt==CLK_DIV-1. First pix_en occurs CLK_DIV clks after rst_L rises.
- Counters: hcnt (10b) and vcnt (10b) advance only on pix_en.
  - hcnt wraps at H_TOT-1 (799) to 0.
  - When hcnt wraps, vcnt increments and wraps at V_TOT-1 (524) to 0.
  - H_TOT = H_VIS+H_FP+H_SYNC+H_BP; V_TOT = V_VIS+V_FP+V_SYNC+V_BP.
- Output registration: every output except pix_en is registered from the next-state counter values. Outputs therefore change on the same edge as the counters and are held constant between pix_en pulses.
- First tick after reset: the first tick leaves hcnt=0, vcnt=0 but recomputes outputs. blank drops to 0, col=0, row=0, and frame_start/line_start pulse.
- Sync decode:
  - HSync=0 for hcnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], i.e. 656..751.
  - VSync=0 for vcnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], i.e. 490..491.
  - Both are independent of blank.
- blank = (hcnt>=H_VIS) | (vcnt>=V_VIS).
- row = vcnt[8:0] when vcnt<V_VIS, else 0. col = hcnt.
- Window arithmetic: 10-bit subtraction; the window check is done before the shift, so no underflow is ever output. win_col spans 0..255 and win_row spans 0..191. Each SMS pixel covers 2x2 VGA pixels.
- Pulses:
  - line_start, frame_start and vblank_irq are high for exactly one clk: the clk following the pix_en edge that produced the condition.
  - At the frame wrap, line_start and frame_start coincide.
  - vblank_irq fires once per frame, when vcnt becomes 480 and hcnt becomes 0.

Optional Feature:
- Macro: VGA_PIPE_ALIGN_EN.
- Defined: HSync, VSync and blank are delayed through one additional pixel-tick register stage, advancing on pix_en only. They then align with the downstream VDP's one-tick VRAM/CRAM lookup latency. row, col, win_* and the pulses are not delayed. Reset values of the delay stage are HSync=1, VSync=1, blank=1.
- Not defined: no extra stage; all outputs are aligned to the counters.

Test Plan:
- Reset release with CLK_DIV=4 -> first pix_en 4 clks after rst_L rises. The next clk shows blank=0, col=0, row=0, frame_start=1 and line_start=1, each for exactly one clk.
- Run 800 pixel ticks -> HSync=0 exactly for col 656..751 (96 ticks); line_start pulses once per 800 ticks (3200 clks); col never exceeds 799.
- Run one full frame -> VSync=0 for lines 490..491; vblank_irq pulses once, at vcnt=480 col=0; frame_start recurs after 420000 ticks (1,680,000 clks).
- Window probe -> col=63,row=48: in_window=0. col=64,row=48: win_col=0, win_row=0. col=575,row=431: win_col=255, win_row=191. col=576: in_window=0, win_col=0.
- Assert rst_L=0 for 1 clk at col=700,row=300 -> next edge shows all outputs at reset values; the subsequent frame restarts from (0,0) with correct sync positions.
- With VGA_PIPE_ALIGN_EN defined -> HSync falls one pixel tick (4 clks) after col becomes 656, and blank rises 4 clks after col becomes 640. Without the macro, both change on the same edge as col.
